// File: rtl/johnson_ring_decoder_4bit.sv
// -----------------------------------------------------------------------------
// johnson_ring_decoder_4bit
// Receive side of a 4-bit Johnson ring counter. The asynchronous code is
// synchronised and glitch-filtered, then decoded to a state index and a
// one-hot vector. Every accepted code is checked for legality and for correct
// sequence stepping, and error statistics are kept.
//
// Optional feature: define JOHNSON_DIRECTION_DETECT_EN to accept reverse
// single steps (idx == prev-1 mod 8) as valid steps and report them on dir.
//
// Ports:
//   CLOCK_50     in   1          system clock (50 MHz)
//   RESET_N      in   1          asynchronous active-low reset
//   code_in      in   4          raw Johnson code {q3,q2,q1,q0}, async
//   clr_err      in   1          sync pulse, clears seq_err and err_count
//   state_idx    out  3          decoded state index 0..7
//   state_onehot out  8          one-hot of state_idx, zero while !valid
//   valid        out  1          last accepted code was legal
//   step         out  1          one-cycle pulse on a correct advance
//   illegal      out  1          one-cycle pulse on an accepted illegal code
//   seq_err      out  1          sticky sequence/legality error flag
//   err_count    out  ERR_CNT_W  saturating error event counter
//   dir          out  1          1 = reverse stepping seen (0 without feature)
// -----------------------------------------------------------------------------
module johnson_ring_decoder_4bit #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [3:0]           code_in,
    input  logic                 clr_err,
    output logic [2:0]           state_idx,
    output logic [7:0]           state_onehot,
    output logic                 valid,
    output logic                 step,
    output logic                 illegal,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 dir
);

    localparam int unsigned CODE_W   = 4;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned CNT_W    = 8;

    localparam logic [CNT_W-1:0]     STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;

    // Johnson code -> {legal, idx}
    function automatic logic [IDX_W:0] johnson_decode(input logic [CODE_W-1:0] code);
        case (code)
            4'b0000: return {1'b1, 3'd0};
            4'b0001: return {1'b1, 3'd1};
            4'b0011: return {1'b1, 3'd2};
            4'b0111: return {1'b1, 3'd3};
            4'b1111: return {1'b1, 3'd4};
            4'b1110: return {1'b1, 3'd5};
            4'b1100: return {1'b1, 3'd6};
            4'b1000: return {1'b1, 3'd7};
            default: return '0;
        endcase
    endfunction

    // Synchroniser chain plus a fill marker so the filter ignores the
    // reset contents of the chain and only sees genuinely sampled codes.
    logic [CODE_W-1:0]      sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sync_vld_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            sync_vld_q <= '0;
        end else begin
            sync_q[0] <= code_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Filter and decoder state
    logic [CODE_W-1:0]    cand_q, cand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CODE_W-1:0]    acc_code_q, acc_code_d;
    logic                 acc_vld_q, acc_vld_d;
    logic                 prev_vld_q, prev_vld_d;
    logic [IDX_W-1:0]     state_idx_d;
    logic [ONEHOT_W-1:0]  state_onehot_d;
    logic                 valid_d, step_d, illegal_d, seq_err_d;
    logic [ERR_CNT_W-1:0] err_count_d, err_base_c;
    logic                 dir_d;
    logic [CODE_W-1:0]    sync_out_c;
    logic                 reached_c, accept_c, err_c, legal_c;
    logic [IDX_W-1:0]     idx_c;

    // Next-state: filter, acceptance, decode, sequence check, statistics
    always_comb begin
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        acc_code_d     = acc_code_q;
        acc_vld_d      = acc_vld_q;
        prev_vld_d     = prev_vld_q;
        state_idx_d    = state_idx;
        state_onehot_d = state_onehot;
        valid_d        = valid;
        step_d         = 1'b0;
        illegal_d      = 1'b0;
        dir_d          = 1'b0;
        reached_c      = 1'b0;
        accept_c       = 1'b0;
        err_c          = 1'b0;
        sync_out_c     = sync_q[SYNC_STAGES-1];
        {legal_c, idx_c} = johnson_decode(cand_q);
`ifdef JOHNSON_DIRECTION_DETECT_EN
        dir_d          = dir;
`endif

        if (sync_vld_q[SYNC_STAGES-1]) begin
            if (sync_out_c != cand_q) begin
                cand_d = sync_out_c;
                cnt_d  = CNT_W'(1);
            end else if (cnt_q != STABLE_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Only the transition into the saturated count is an event
            reached_c = (cnt_d == STABLE_MAX) &&
                        ((cnt_q != STABLE_MAX) || (cand_d != cand_q));
            accept_c  = reached_c && (!acc_vld_q || (cand_d != acc_code_q));
        end

        {legal_c, idx_c} = johnson_decode(cand_d);

        if (accept_c) begin
            acc_code_d = cand_d;
            acc_vld_d  = 1'b1;
            if (!legal_c) begin
                illegal_d      = 1'b1;
                valid_d        = 1'b0;
                state_onehot_d = '0;
                prev_vld_d     = 1'b0;
                err_c          = 1'b1;
            end else begin
                state_idx_d    = idx_c;
                state_onehot_d = ONEHOT_W'(1) << idx_c;
                valid_d        = 1'b1;
                prev_vld_d     = 1'b1;
                if (prev_vld_q) begin
                    if (idx_c == state_idx + IDX_W'(1)) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
`ifdef JOHNSON_DIRECTION_DETECT_EN
                    end else if (idx_c == state_idx - IDX_W'(1)) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
`endif
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
        end

        // Clear applies first so a coincident error still counts once
        err_base_c = clr_err ? '0 : err_count;
        if (err_c) begin
            seq_err_d   = 1'b1;
            err_count_d = (err_base_c == ERR_MAX) ? err_base_c : err_base_c + ERR_CNT_W'(1);
        end else begin
            seq_err_d   = clr_err ? 1'b0 : seq_err;
            err_count_d = err_base_c;
        end
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cand_q       <= '0;
            cnt_q        <= '0;
            acc_code_q   <= '0;
            acc_vld_q    <= 1'b0;
            prev_vld_q   <= 1'b0;
            state_idx    <= '0;
            state_onehot <= '0;
            valid        <= 1'b0;
            step         <= 1'b0;
            illegal      <= 1'b0;
            seq_err      <= 1'b0;
            err_count    <= '0;
        end else begin
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            acc_code_q   <= acc_code_d;
            acc_vld_q    <= acc_vld_d;
            prev_vld_q   <= prev_vld_d;
            state_idx    <= state_idx_d;
            state_onehot <= state_onehot_d;
            valid        <= valid_d;
            step         <= step_d;
            illegal      <= illegal_d;
            seq_err      <= seq_err_d;
            err_count    <= err_count_d;
        end
    end

`ifdef JOHNSON_DIRECTION_DETECT_EN
    // Direction flag holds between stepping events
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dir <= 1'b0;
        end else begin
            dir <= dir_d;
        end
    end
`else
    logic unused_dir_c;
    assign unused_dir_c = dir_d;
    assign dir          = 1'b0;
`endif

endmodule
